// File: rtl/reg_bus_pkg.sv
// Shared types and helpers for the two-master register-bus arbiter.
package reg_bus_pkg;

    localparam int ADDRESS_WIDTH_DEFAULT = 8;

    // Arbiter FSM: idle between transactions, waiting while one is in flight.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Timeout counter must be able to hold TIMEOUT_CYCLES itself.
    function automatic int counter_width(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/reg_bus_req_slot.sv
// One request slot per master: latches a request pulse and its payload
// until the arbiter issues it to the target.
module reg_bus_req_slot
    import reg_bus_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     request,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic                     is_write,
    input  logic [7:0]               write_data,
    input  logic                     clear,
    output logic                     pend,
    output logic [ADDRESS_WIDTH-1:0] slot_address,
    output logic                     slot_is_write,
    output logic [7:0]               slot_write_data
);

    // Capture the latest request; a new request outranks the arbiter's clear.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            // NOTE: payload registers are reset too so the slot never exposes X on the target bus.
            pend            <= 1'b0;
            slot_address    <= '0;
            slot_is_write   <= 1'b0;
            slot_write_data <= 8'h00;
        end else begin
            // NOTE: request is tested before clear so a request landing on the issue edge is not lost.
            if (request) begin
                pend            <= 1'b1;
                slot_address    <= address;
                slot_is_write   <= is_write;
                slot_write_data <= write_data;
            end else if (clear) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one register-bus target between two masters,
// one transaction in flight, with a timeout response if the target is silent.
module reg_bus_arbiter
    import reg_bus_pkg::*;
#(
    parameter int         ADDRESS_WIDTH  = ADDRESS_WIDTH_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 255,
    parameter logic [7:0] TIMEOUT_DATA   = 8'hFF
) (
    input  logic                     clock,
    input  logic                     reset_n,
    // master 0
    input  logic                     m0_request,
    input  logic [ADDRESS_WIDTH-1:0] m0_address,
    input  logic                     m0_is_write,
    input  logic [7:0]               m0_write_data,
    output logic                     m0_response,
    output logic [7:0]               m0_read_data,
    output logic                     m0_error,
    // master 1
    input  logic                     m1_request,
    input  logic [ADDRESS_WIDTH-1:0] m1_address,
    input  logic                     m1_is_write,
    input  logic [7:0]               m1_write_data,
    output logic                     m1_response,
    output logic [7:0]               m1_read_data,
    output logic                     m1_error,
    // target
    output logic                     s_request,
    output logic [ADDRESS_WIDTH-1:0] s_address,
    output logic                     s_is_write,
    output logic [7:0]               s_write_data,
    input  logic                     s_response,
    input  logic [7:0]               s_read_data
);

    localparam int COUNT_W = counter_width(TIMEOUT_CYCLES);
    localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(TIMEOUT_CYCLES - 1);

    logic                     pend0, pend1;
    logic [ADDRESS_WIDTH-1:0] slot0_address, slot1_address;
    logic                     slot0_is_write, slot1_is_write;
    logic [7:0]               slot0_write_data, slot1_write_data;

    state_t               state;
    logic                 grant;      // master owning the in-flight transaction
    logic                 prio;       // master preferred when both are pending
    logic [COUNT_W-1:0]   counter;

    logic                 issue;
    logic                 winner;
    logic                 clear0, clear1;
    logic                 timeout_hit;
    logic                 done;
    logic [7:0]           done_data;
    logic                 done_error;

    reg_bus_req_slot #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_slot0 (
        .clock           (clock),
        .reset_n         (reset_n),
        .request         (m0_request),
        .address         (m0_address),
        .is_write        (m0_is_write),
        .write_data      (m0_write_data),
        .clear           (clear0),
        .pend            (pend0),
        .slot_address    (slot0_address),
        .slot_is_write   (slot0_is_write),
        .slot_write_data (slot0_write_data)
    );

    reg_bus_req_slot #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_slot1 (
        .clock           (clock),
        .reset_n         (reset_n),
        .request         (m1_request),
        .address         (m1_address),
        .is_write        (m1_is_write),
        .write_data      (m1_write_data),
        .clear           (clear1),
        .pend            (pend1),
        .slot_address    (slot1_address),
        .slot_is_write   (slot1_is_write),
        .slot_write_data (slot1_write_data)
    );

    // Pick the winner and decide how the in-flight transaction completes.
    always_comb begin
        issue       = (state == ST_IDLE) && (pend0 || pend1);
        winner      = (pend0 && pend1) ? prio : pend1;
        clear0      = issue && !winner;
        clear1      = issue && winner;
        timeout_hit = (counter == COUNT_LAST);
        done        = (state == ST_WAIT) && (s_response || timeout_hit);
        // A real answer beats a coincident timeout.
        done_data   = s_response ? s_read_data : TIMEOUT_DATA;
        done_error  = !s_response;
    end

    // Arbiter FSM with registered target request and master responses.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            grant        <= 1'b0;
            prio         <= 1'b0;
            counter      <= '0;
            s_request    <= 1'b0;
            s_address    <= '0;
            s_is_write   <= 1'b0;
            s_write_data <= 8'h00;
            m0_response  <= 1'b0;
            m0_read_data <= 8'h00;
            m0_error     <= 1'b0;
            m1_response  <= 1'b0;
            m1_read_data <= 8'h00;
            m1_error     <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here and are overridden below; non-blocking keeps the last write.
            s_request   <= 1'b0;
            m0_response <= 1'b0;
            m0_error    <= 1'b0;
            m1_response <= 1'b0;
            m1_error    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        s_request    <= 1'b1;
                        s_address    <= winner ? slot1_address    : slot0_address;
                        s_is_write   <= winner ? slot1_is_write   : slot0_is_write;
                        s_write_data <= winner ? slot1_write_data : slot0_write_data;
                        grant        <= winner;
                        counter      <= '0;
                        state        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    counter <= counter + 1'b1;
                    if (done) begin
                        if (grant) begin
                            m1_response  <= 1'b1;
                            m1_read_data <= done_data;
                            m1_error     <= done_error;
                        end else begin
                            m0_response  <= 1'b1;
                            m0_read_data <= done_data;
                            m0_error     <= done_error;
                        end
                        prio  <= ~grant;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Self-checking bench for reg_bus_arbiter: a behavioural target, a scoreboard
// of expected target issues and master responses, and directed latency checks.
module tb_reg_bus_arbiter;
    import reg_bus_pkg::*;

    logic       clock;
    logic       reset_n;
    logic       m0_request, m0_is_write, m0_response, m0_error;
    logic [7:0] m0_address, m0_write_data, m0_read_data;
    logic       m1_request, m1_is_write, m1_response, m1_error;
    logic [7:0] m1_address, m1_write_data, m1_read_data;
    logic       s_request, s_is_write, s_response;
    logic [7:0] s_address, s_write_data, s_read_data;

    reg_bus_arbiter #(
        .ADDRESS_WIDTH  (8),
        .TIMEOUT_CYCLES (4),
        .TIMEOUT_DATA   (8'hFF)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .m0_request    (m0_request),
        .m0_address    (m0_address),
        .m0_is_write   (m0_is_write),
        .m0_write_data (m0_write_data),
        .m0_response   (m0_response),
        .m0_read_data  (m0_read_data),
        .m0_error      (m0_error),
        .m1_request    (m1_request),
        .m1_address    (m1_address),
        .m1_is_write   (m1_is_write),
        .m1_write_data (m1_write_data),
        .m1_response   (m1_response),
        .m1_read_data  (m1_read_data),
        .m1_error      (m1_error),
        .s_request     (s_request),
        .s_address     (s_address),
        .s_is_write    (s_is_write),
        .s_write_data  (s_write_data),
        .s_response    (s_response),
        .s_read_data   (s_read_data)
    );

    typedef struct {
        logic [7:0] address;
        logic       is_write;
        logic [7:0] write_data;
    } s_exp_t;

    typedef struct {
        int         master;
        logic [7:0] read_data;
        logic       error;
    } r_exp_t;

    s_exp_t s_q[$];
    r_exp_t rsp_q[$];

    int checks = 0;
    int errors = 0;
    int n_m0_resp = 0;

    // target model controls
    int   tgt_delay  = 1;
    logic tgt_silent = 1'b0;
    logic stray_pulse = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rd_model(input logic [7:0] a);
        return a ^ 8'h4A;
    endfunction

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural target: answers tgt_delay cycles after s_request unless silent.
    initial begin
        logic       busy;
        int         cnt;
        logic [7:0] addr;
        busy = 1'b0;
        cnt = 0;
        addr = 8'h00;
        s_response = 1'b0;
        s_read_data = 8'h00;
        forever begin
            @(posedge clock);
            #2;
            s_response = 1'b0;
            if (stray_pulse) begin
                s_response  = 1'b1;
                s_read_data = 8'hC3;
                stray_pulse = 1'b0;
            end
            if (s_request && !tgt_silent) begin
                busy = 1'b1;
                cnt  = tgt_delay;
                addr = s_address;
            end
            if (busy) begin
                if (cnt == 0) begin
                    s_response  = 1'b1;
                    s_read_data = rd_model(addr);
                    busy        = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Scoreboard monitor: every target issue and master response must be expected.
    initial begin
        s_exp_t se;
        r_exp_t re;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (s_request) begin
                    if (s_q.size() == 0) begin
                        check("s_request_unexpected", 1, 0);
                    end else begin
                        se = s_q.pop_front();
                        check("s_address", s_address, se.address);
                        check("s_is_write", s_is_write, se.is_write);
                        check("s_write_data", s_write_data, se.write_data);
                    end
                end
                for (int m = 0; m < 2; m++) begin
                    if ((m == 0) ? m0_response : m1_response) begin
                        if (m == 0) n_m0_resp++;
                        if (rsp_q.size() == 0) begin
                            check("response_unexpected", 1, 0);
                        end else begin
                            re = rsp_q.pop_front();
                            check("rsp_master", m, re.master);
                            check("rsp_read_data", (m == 0) ? m0_read_data : m1_read_data, re.read_data);
                            check("rsp_error", (m == 0) ? m0_error : m1_error, re.error);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        m0_request = 1'b0;
        m1_request = 1'b0;
    endtask

    task automatic set_req(input int m, input logic [7:0] a, input logic w, input logic [7:0] d);
        if (m == 0) begin
            m0_request = 1'b1; m0_address = a; m0_is_write = w; m0_write_data = d;
        end else begin
            m1_request = 1'b1; m1_address = a; m1_is_write = w; m1_write_data = d;
        end
    endtask

    task automatic expect_txn(input int m, input logic [7:0] a, input logic w, input logic [7:0] d);
        s_exp_t se;
        r_exp_t re;
        se.address = a; se.is_write = w; se.write_data = d;
        re.master = m; re.read_data = rd_model(a); re.error = 1'b0;
        s_q.push_back(se);
        rsp_q.push_back(re);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (s_q.size() == 0 && rsp_q.size() == 0) break;
            tick();
        end
        check(tag, s_q.size() + rsp_q.size(), 0);
        s_q.delete();
        rsp_q.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n0, n1;
        int resp_before;
        s_exp_t se;
        r_exp_t re;

        reset_n = 1'b0;
        m0_request = 1'b0; m0_address = 8'h00; m0_is_write = 1'b0; m0_write_data = 8'h00;
        m1_request = 1'b0; m1_address = 8'h00; m1_is_write = 1'b0; m1_write_data = 8'h00;
        do_reset();

        // reset state
        check("rst_s_request", s_request, 0);
        check("rst_s_address", s_address, 0);
        check("rst_m0_response", m0_response, 0);
        check("rst_m1_response", m1_response, 0);
        check("rst_m0_error", m0_error, 0);
        check("rst_state", dut.state, ST_IDLE);

        // 1: m0 read 0x10, target answers one cycle after s_request
        tgt_delay = 1;
        set_req(0, 8'h10, 1'b0, 8'h00);
        expect_txn(0, 8'h10, 1'b0, 8'h00);
        tick();
        check("t1_sreq_t1", s_request, 0);
        tick();
        check("t1_sreq_t2", s_request, 1);
        tick();
        check("t1_resp_t3", m0_response, 0);
        tick();
        check("t1_resp_t4", m0_response, 1);
        check("t1_data_t4", m0_read_data, 8'h5A);
        check("t1_err_t4", m0_error, 0);
        check("t1_m1_quiet", m1_response, 0);
        wait_drain("t1_drained", 20);

        // 2: simultaneous requests after reset, m0 served first
        do_reset();
        set_req(0, 8'h01, 1'b1, 8'hAA);
        set_req(1, 8'h02, 1'b0, 8'h00);
        expect_txn(0, 8'h01, 1'b1, 8'hAA);
        expect_txn(1, 8'h02, 1'b0, 8'h00);
        tick();
        wait_drain("t2_drained", 40);

        // 3: both masters re-request on every completion, grants must alternate
        tgt_delay = 0;
        for (int i = 0; i < 4; i++) begin
            expect_txn(0, 8'h30 + 8'(i), 1'b1, 8'(i));
            expect_txn(1, 8'h40 + 8'(i), 1'b0, 8'h00);
        end
        set_req(0, 8'h30, 1'b1, 8'h00);
        set_req(1, 8'h40, 1'b0, 8'h00);
        n0 = 1;
        n1 = 1;
        for (int c = 0; c < 200 && (n0 < 4 || n1 < 4); c++) begin
            tick();
            if (m0_response && n0 < 4) begin
                set_req(0, 8'h30 + 8'(n0), 1'b1, 8'(n0));
                n0++;
            end
            if (m1_response && n1 < 4) begin
                set_req(1, 8'h40 + 8'(n1), 1'b0, 8'h00);
                n1++;
            end
        end
        check("t3_all_requested", n0 + n1, 8);
        wait_drain("t3_drained", 60);

        // 4: silent target, timeout after four WAIT cycles
        tgt_silent = 1'b1;
        set_req(1, 8'h55, 1'b0, 8'h00);
        se.address = 8'h55; se.is_write = 1'b0; se.write_data = 8'h00;
        s_q.push_back(se);
        re.master = 1; re.read_data = 8'hFF; re.error = 1'b1;
        rsp_q.push_back(re);
        cyc = 0;
        while (!m1_response && cyc < 20) begin
            tick();
            cyc++;
        end
        check("t4_latency", cyc, 6);
        check("t4_error", m1_error, 1);
        check("t4_data", m1_read_data, 8'hFF);
        check("t4_state_idle", dut.state, ST_IDLE);
        tick();
        check("t4_resp_pulse", m1_response, 0);
        check("t4_data_held", m1_read_data, 8'hFF);
        wait_drain("t4_drained", 20);

        // 5: reset while in WAIT, stray s_response afterwards is ignored
        set_req(0, 8'h66, 1'b0, 8'h00);
        se.address = 8'h66; se.is_write = 1'b0; se.write_data = 8'h00;
        s_q.push_back(se);
        tick();
        tick();
        tick();
        check("t5_in_wait", dut.state, ST_WAIT);
        do_reset();
        check("t5_s_request", s_request, 0);
        check("t5_s_address", s_address, 0);
        check("t5_m0_response", m0_response, 0);
        check("t5_m1_read_data", m1_read_data, 0);
        check("t5_m0_read_data", m0_read_data, 0);
        stray_pulse = 1'b1;
        resp_before = n_m0_resp;
        for (int i = 0; i < 4; i++) tick();
        check("t5_no_resp_m0", m0_response, 0);
        check("t5_no_resp_count", n_m0_resp - resp_before, 0);
        check("t5_state_idle", dut.state, ST_IDLE);
        tgt_silent = 1'b0;
        tgt_delay = 1;
        set_req(1, 8'h77, 1'b1, 8'h12);
        expect_txn(1, 8'h77, 1'b1, 8'h12);
        tick();
        wait_drain("t5_drained", 20);

        // 6: m0 requests twice while m1 is in flight, last request wins
        tgt_delay = 3;
        set_req(1, 8'h08, 1'b0, 8'h00);
        expect_txn(1, 8'h08, 1'b0, 8'h00);
        tick();
        tick();
        set_req(0, 8'h20, 1'b0, 8'h00);
        tick();
        set_req(0, 8'h21, 1'b1, 8'h99);
        expect_txn(0, 8'h21, 1'b1, 8'h99);
        resp_before = n_m0_resp;
        tick();
        wait_drain("t6_drained", 40);
        for (int i = 0; i < 6; i++) tick();
        check("t6_single_m0_resp", n_m0_resp - resp_before, 1);
        check("t6_sq_empty", s_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
